// File: rtl/fp32_pkg.sv
// Shared FP32 constants, special-operand class encoding and exception flag layout
// used by the multiply and add datapaths.
package fp32_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int FRAC_W   = 23;
  localparam int SIG_W    = 24;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'b00,
    CLS_ZERO   = 2'b01,
    CLS_INF    = 2'b10,
    CLS_NAN    = 2'b11
  } fp_class_e;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic inx;
  } fp_flags_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a 24-bit significand with guard and sticky bits;
// shared by the multiply and add paths.
module fp_round_rne
  import fp32_pkg::*;
(
  input  logic [SIG_W-1:0] mant24,
  input  logic             g,
  input  logic             s,
  output logic [SIG_W-1:0] mant,
  output logic             carry,
  output logic             inexact
);

  logic             inc;
  logic [SIG_W:0]   sum;

  assign inc     = g & (s | mant24[0]);
  assign sum     = {1'b0, mant24} + {{SIG_W{1'b0}}, inc};
  assign mant    = sum[SIG_W-1:0];
  assign carry   = sum[SIG_W];
  assign inexact = g | s;

endmodule

// File: rtl/fp32_mul_norm_round.sv
// Normalize / round / pack stage of the FP32 multiplier, two-stage elastic pipeline.
// Define FP_MUL_SUBNORM_EN for gradual underflow; otherwise tiny results flush to zero.
module fp32_mul_norm_round
  import fp32_pkg::*;
#(
  parameter int PROD_W = 48,
  parameter int EXP_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [PROD_W-1:0] in_prod,
  input  logic [1:0]        in_class,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [2:0]        out_flags
);

  // One extra bit so in_exp+1 never wraps.
  localparam int EW = EXP_W + 1;

  logic              v1, v2, ready2;
  logic [EW-1:0]     exp_ext, n_exp;
  logic [SIG_W-1:0]  n_mant;
  logic              n_g, n_s, n_tiny;

  logic              s1_sign, s1_g, s1_s, s1_tiny;
  fp_class_e         s1_class;
  logic [EW-1:0]     s1_exp;
  logic [SIG_W-1:0]  s1_mant;

  logic [SIG_W-1:0]  r_mant;
  logic              r_carry, r_inx;
  logic [EW-1:0]     e_r;
  logic [31:0]       n2_result;
  fp_flags_t         n2_flags;

`ifdef FP_MUL_SUBNORM_EN
  logic [EW-1:0]       sh_full;
  logic [4:0]          sh;
  logic [SIG_W+26:0]   shift_vec;
`endif

  assign ready2    = !v2 || out_ready;
  assign in_ready  = !v1 || ready2;
  assign out_valid = v2;
  assign exp_ext   = {in_exp[EXP_W-1], in_exp};

  always_comb begin
    if (in_prod[PROD_W-1]) begin
      n_mant = in_prod[PROD_W-1 -: SIG_W];
      n_g    = in_prod[PROD_W-1-SIG_W];
      n_s    = |in_prod[PROD_W-2-SIG_W:0];
      n_exp  = exp_ext + EW'(1);
    end else begin
      n_mant = in_prod[PROD_W-2 -: SIG_W];
      n_g    = in_prod[PROD_W-2-SIG_W];
      n_s    = |in_prod[PROD_W-3-SIG_W:0];
      n_exp  = exp_ext;
    end
    n_tiny = n_exp[EW-1] || (n_exp == '0);
`ifdef FP_MUL_SUBNORM_EN
    // Denormalize by 1-e; the 26 zero pad bits mean nothing is lost below sticky.
    sh_full   = EW'(1) - n_exp;
    sh        = (sh_full > EW'(26)) ? 5'd26 : sh_full[4:0];
    shift_vec = {n_mant, n_g, 26'b0} >> sh;
    if (n_tiny) begin
      n_mant = shift_vec[SIG_W+26:27];
      n_g    = shift_vec[26];
      n_s    = n_s | (|shift_vec[25:0]);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      s1_sign  <= 1'b0;
      s1_class <= CLS_ZERO;
      s1_exp   <= '0;
      s1_mant  <= '0;
      s1_g     <= 1'b0;
      s1_s     <= 1'b0;
      s1_tiny  <= 1'b0;
    end else if (in_ready) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_sign  <= in_sign;
        s1_class <= fp_class_e'(in_class);
        s1_exp   <= n_exp;
        s1_mant  <= n_mant;
        s1_g     <= n_g;
        s1_s     <= n_s;
        s1_tiny  <= n_tiny;
      end
    end
  end

  fp_round_rne u_rne (
    .mant24  (s1_mant),
    .g       (s1_g),
    .s       (s1_s),
    .mant    (r_mant),
    .carry   (r_carry),
    .inexact (r_inx)
  );

  always_comb begin
    e_r       = s1_exp + {{(EW-1){1'b0}}, r_carry};
    n2_result = {s1_sign, 31'h0};
    n2_flags  = '0;
    case (s1_class)
      CLS_ZERO: n2_result = {s1_sign, 31'h0};
      CLS_INF:  n2_result = {s1_sign, PINF[30:0]};
      CLS_NAN:  n2_result = QNAN;
      default: begin
        if (s1_tiny) begin
`ifdef FP_MUL_SUBNORM_EN
          // A carry into the hidden bit promotes the subnormal to min normal.
          n2_result    = {s1_sign, 7'h0, r_mant[FRAC_W], r_mant[FRAC_W-1:0]};
          n2_flags.unf = !r_mant[FRAC_W] && r_inx;
          n2_flags.inx = r_inx;
`else
          n2_result    = {s1_sign, 31'h0};
          n2_flags.unf = 1'b1;
          n2_flags.inx = 1'b1;
`endif
        end else if (!e_r[EW-1] && (e_r[EW-2:0] >= (EW-1)'(EXP_MAX))) begin
          n2_result    = {s1_sign, PINF[30:0]};
          n2_flags.ovf = 1'b1;
          n2_flags.inx = 1'b1;
        end else begin
          n2_result    = {s1_sign, e_r[7:0], r_mant[FRAC_W-1:0]};
          n2_flags.inx = r_inx;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2         <= 1'b0;
      out_result <= 32'h0;
      out_flags  <= 3'b0;
    end else if (ready2) begin
      v2 <= v1;
      if (v1) begin
        out_result <= n2_result;
        out_flags  <= n2_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp32_mul_norm_round.sv
// Directed scoreboard bench for fp32_mul_norm_round; expectations follow
// FP_MUL_SUBNORM_EN when it is defined for the build.
module tb_fp32_mul_norm_round;

  typedef struct {
    string       tag;
    logic [31:0] result;
    logic [2:0]  flags;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_prod;
  logic [1:0]  in_class;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  exp_t sb[$];
  exp_t mon_item;
  int   pass_count  = 0;
  int   total_count = 0;

  fp32_mul_norm_round dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_prod    (in_prod),
    .in_class   (in_class),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Drives one op, holds it until accepted, and queues its expected result.
  task automatic applyStimulus(input string tag, input logic sign, input logic [9:0] exp_in,
                               input logic [47:0] prod, input logic [1:0] cls,
                               input logic [31:0] exp_result, input logic [2:0] exp_flags);
    int waited = 0;
    exp_t item;
    assert (!(cls == 2'b00 && prod[47:46] == 2'b00))
    else $error("[TB] illegal normal product without hidden one in %s", tag);
    in_valid = 1'b1;
    in_sign  = sign;
    in_exp   = exp_in;
    in_prod  = prod;
    in_class = cls;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      total_count++;
      $error("[TB] FAIL %s_accept observed=in_ready_low expected=accept_within_50", tag);
    end else begin
      item.tag    = tag;
      item.result = exp_result;
      item.flags  = exp_flags;
      sb.push_back(item);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total_count++;
      $error("[TB] FAIL drain observed=%0d_pending expected=0_pending", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total_count++;
        $error("[TB] FAIL unexpected_output observed=%h expected=none", out_result);
      end else begin
        mon_item = sb.pop_front();
        checkOutput({mon_item.tag, "_result"}, out_result, mon_item.result);
        checkOutput({mon_item.tag, "_flags"}, {29'b0, out_flags}, {29'b0, mon_item.flags});
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_prod   = '0;
    in_class  = 2'b00;
    out_ready = 1'b1;
    #1;
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("reset_out_result", out_result, 32'h0);
    checkOutput("reset_out_flags", {29'b0, out_flags}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset_in_ready", {31'b0, in_ready}, 32'h1);

    applyStimulus("mul_1p5x1p5", 1'b0, 10'd127, 48'h900000000000, 2'b00, 32'h40100000, 3'b000);
    @(negedge clk);
    checkOutput("latency_cycle1", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    checkOutput("latency_cycle2", {31'b0, out_valid}, 32'h1);
    drain();

    applyStimulus("rne_up", 1'b0, 10'd127, 48'h400000C00000, 2'b00, 32'h3F800002, 3'b001);
    applyStimulus("rne_tie_even", 1'b0, 10'd127, 48'h400000400000, 2'b00, 32'h3F800000, 3'b001);
    applyStimulus("rne_carry", 1'b0, 10'd127, 48'h7FFFFFC00000, 2'b00, 32'h40000000, 3'b001);
    applyStimulus("rne_sticky_hi", 1'b0, 10'd127, 48'hC00000800001, 2'b00, 32'h40400001, 3'b001);
    applyStimulus("neg_normal", 1'b1, 10'd127, 48'h900000000000, 2'b00, 32'hC0100000, 3'b000);
    applyStimulus("max_exp", 1'b0, 10'd254, 48'h400000000000, 2'b00, 32'h7F000000, 3'b000);
    applyStimulus("overflow", 1'b0, 10'd254, 48'h800000000000, 2'b00, 32'h7F800000, 3'b101);
`ifdef FP_MUL_SUBNORM_EN
    applyStimulus("underflow", 1'b0, 10'd0, 48'h400000000000, 2'b00, 32'h00400000, 3'b000);
    applyStimulus("deep_subnorm", 1'b0, 10'h3F0, 48'h400000000000, 2'b00, 32'h00000040, 3'b000);
`else
    applyStimulus("underflow", 1'b0, 10'd0, 48'h400000000000, 2'b00, 32'h00000000, 3'b011);
    applyStimulus("deep_subnorm", 1'b0, 10'h3F0, 48'h400000000000, 2'b00, 32'h00000000, 3'b011);
`endif
    applyStimulus("shift_saturate", 1'b0, 10'h39C, 48'h400000000000, 2'b00, 32'h00000000, 3'b011);
    applyStimulus("special_nan", 1'b1, 10'd5, 48'h123456789ABC, 2'b11, 32'h7FC00000, 3'b000);
    applyStimulus("special_neg_inf", 1'b1, 10'd5, 48'h800000000000, 2'b10, 32'hFF800000, 3'b000);
    applyStimulus("special_neg_zero", 1'b1, 10'd200, 48'h800000000000, 2'b01, 32'h80000000, 3'b000);
    drain();

    out_ready = 1'b0;
    fork
      begin
        applyStimulus("bp_op1", 1'b0, 10'd127, 48'h900000000000, 2'b00, 32'h40100000, 3'b000);
        applyStimulus("bp_op2", 1'b0, 10'd127, 48'h400000400000, 2'b00, 32'h3F800000, 3'b001);
        applyStimulus("bp_op3", 1'b1, 10'd127, 48'h900000000000, 2'b00, 32'hC0100000, 3'b000);
        applyStimulus("bp_op4", 1'b0, 10'd127, 48'h7FFFFFC00000, 2'b00, 32'h40000000, 3'b001);
      end
      begin
        repeat (3) @(negedge clk);
        checkOutput("bp_in_ready_low", {31'b0, in_ready}, 32'h0);
        checkOutput("bp_hold_result_a", out_result, 32'h40100000);
        @(negedge clk);
        checkOutput("bp_hold_result_b", out_result, 32'h40100000);
        checkOutput("bp_hold_valid", {31'b0, out_valid}, 32'h1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    applyStimulus("rst_drop_a", 1'b0, 10'd127, 48'h900000000000, 2'b00, 32'h40100000, 3'b000);
    applyStimulus("rst_drop_b", 1'b0, 10'd127, 48'h400000C00000, 2'b00, 32'h3F800002, 3'b001);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_out_valid", {31'b0, out_valid}, 32'h0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("post_release_no_stale", {31'b0, out_valid}, 32'h0);
    end
    @(posedge clk);
    #1;
    applyStimulus("after_reset", 1'b0, 10'd127, 48'h400000400000, 2'b00, 32'h3F800000, 3'b001);
    drain();

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
